// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a shared 12-op combinational ALU.
// Commands are accepted over valid/ready, held on the ALU for EXEC_CYCLES cycles, and returned with an error flag.
module alu_share_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [23:0] req_op,
    input  logic [15:0] req_src1,
    input  logic [15:0] req_src2,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [7:0]  rsp_result,
    output logic        rsp_err,
    output logic [11:0] alu_op,
    output logic [7:0]  alu_src1,
    output logic [7:0]  alu_src2,
    input  logic [7:0]  alu_result
);

    localparam int unsigned OP_W  = 12;
    localparam int unsigned D_W   = 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              gnt_q, gnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [D_W-1:0]    src1_q, src1_d;
    logic [D_W-1:0]    src2_q, src2_d;
    logic [D_W-1:0]    result_q, result_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  exec_cnt_q, exec_cnt_d;

    logic              gnt_sel;
    logic [OP_W-1:0]   sel_op;
    logic [D_W-1:0]    sel_src1;
    logic [D_W-1:0]    sel_src2;
    logic              sel_onehot;

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            gnt_q      <= 1'b0;
            op_q       <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            exec_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            op_q       <= op_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            result_q   <= result_d;
            err_q      <= err_d;
            exec_cnt_q <= exec_cnt_d;
        end
    end

    // Round-robin pick: the pointer's requester if valid, otherwise the other one
    always_comb begin
        gnt_sel    = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
        sel_op     = gnt_sel ? req_op[23:12]  : req_op[11:0];
        sel_src1   = gnt_sel ? req_src1[15:8] : req_src1[7:0];
        sel_src2   = gnt_sel ? req_src2[15:8] : req_src2[7:0];
        sel_onehot = (sel_op != '0) && ((sel_op & (sel_op - OP_W'(1))) == '0);
    end

    // Next-state and handshake logic
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        op_d       = op_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        result_d   = result_q;
        err_d      = err_q;
        exec_cnt_d = exec_cnt_q;
        req_ready  = '0;

        case (state_q)
            IDLE: begin
                if (resetn && (|req_valid)) begin
                    req_ready[gnt_sel] = 1'b1;
                    gnt_d              = gnt_sel;
                    exec_cnt_d         = '0;
                    if (sel_onehot) begin
                        op_d    = sel_op;
                        src1_d  = sel_src1;
                        src2_d  = sel_src2;
                        err_d   = 1'b0;
                        state_d = EXEC;
                    end else begin
                        // Illegal op skips the ALU entirely
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            EXEC: begin
                if (exec_cnt_q == CNT_W'(EXEC_CYCLES - 1)) begin
                    result_d   = alu_result;
                    exec_cnt_d = '0;
                    state_d    = RESP;
                end else begin
                    exec_cnt_d = exec_cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready[gnt_q]) begin
                    rr_ptr_d = ~gnt_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_op     = (state_q == EXEC) ? op_q : '0;
    assign alu_src1   = src1_q;
    assign alu_src2   = src2_q;
    assign rsp_valid  = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;

endmodule
